// File: rtl/instr_byte_fetch_if.sv
// Bundle of the byte-fetch stage's bus signals: memory request/response,
// redirect from branch resolution, and the instr valid/ready stream.
// master = fetch stage side, slave = memory / consumer / redirect source side.
interface instr_byte_fetch_if #(
    parameter int ADDR_W = 16
);
    // memory request / response
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [7:0]        mem_rdata;
    // redirect from branch/jump resolution
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    // byte stream to the macro-op fetch
    logic [7:0]        instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output mem_addr, mem_req, instr, instr_pc, instr_valid,
        input  mem_ready, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_addr, mem_req, instr, instr_pc, instr_valid,
        output mem_ready, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_byte_fetch.sv
// Byte fetch: reads the FFFC/FFFD reset vector, then streams sequential bytes into a FIFO.
// Latency: request accepted at T, response T+1, byte valid at T+2 (no bypass).
// Backpressure: requests stop once occupancy + in-flight reaches DEPTH; redirect flushes.
//
// Ports: clk_i, rst_ni (async active-low); bus (master modport) carries
// mem_addr/mem_req/mem_ready/mem_rvalid/mem_rdata, redirect/redirect_pc,
// instr/instr_pc/instr_valid/instr_ready.
module instr_byte_fetch #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    instr_byte_fetch_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CW1   = CNT_W + 1;

    localparam logic [1:0] ST_VEC_LO   = 2'd0;
    localparam logic [1:0] ST_VEC_HI   = 2'd1;
    localparam logic [1:0] ST_VEC_WAIT = 2'd2;
    localparam logic [1:0] ST_RUN      = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              inflight_q, inflight_d;
    logic [7:0]        vec_lo_q, vec_lo_d;

    logic [7:0]        data_q [DEPTH];
    logic [ADDR_W-1:0] epc_q  [DEPTH];

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              accept;
    logic              push;
    logic              pop;
    logic [CW1-1:0]    credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The in-flight response already owns a slot; a same-cycle pop earns no
    // credit, so a returning byte always finds room.
    assign credit_used = {1'b0, count_q} + CW1'(inflight_q);

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc_q;
        case (state_q)
            ST_VEC_LO: begin
                mem_req  = 1'b1;
                mem_addr = ADDR_W'(16'hFFFC);
            end
            ST_VEC_HI: begin
                mem_req  = 1'b1;
                mem_addr = ADDR_W'(16'hFFFD);
            end
            ST_RUN:  mem_req = (credit_used < CW1'(DEPTH));
            default: mem_req = 1'b0;
        endcase
        if (bus.redirect) begin
            mem_req = 1'b0;
        end
    end

    assign accept = mem_req & bus.mem_ready;
    // Only RUN-state responses carry stream bytes; vector bytes are never queued.
    assign push   = (state_q == ST_RUN) & bus.mem_rvalid & inflight_q & ~bus.redirect;
    assign pop    = (count_q != '0) & bus.instr_ready & ~bus.redirect;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        vec_lo_d   = vec_lo_q;
        inflight_d = accept;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        case (state_q)
            ST_VEC_LO: begin
                if (accept) begin
                    state_d = ST_VEC_HI;
                end
            end
            ST_VEC_HI: begin
                // The FFFC response lands in the first VEC_HI cycle.
                if (bus.mem_rvalid & inflight_q) begin
                    vec_lo_d = bus.mem_rdata;
                end
                if (accept) begin
                    state_d = ST_VEC_WAIT;
                end
            end
            ST_VEC_WAIT: begin
                // VEC_WAIT is only entered right after the FFFD accept, so the
                // high byte is on mem_rdata now.
                pc_d    = ADDR_W'({bus.mem_rdata, vec_lo_q});
                state_d = ST_RUN;
            end
            default: begin
                if (accept) begin
                    pc_d       = pc_q + ADDR_W'(1);
                    req_addr_d = pc_q;
                end
            end
        endcase

        if (push) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.redirect) begin
            state_d    = ST_RUN;
            pc_d       = bus.redirect_pc;
            inflight_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_VEC_LO;
            pc_q       <= '0;
            req_addr_q <= '0;
            vec_lo_q   <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            vec_lo_q   <= vec_lo_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage is zeroed so instr/instr_pc read 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                epc_q[i]  <= '0;
            end
        end else if (push) begin
            data_q[tail_q] <= bus.mem_rdata;
            epc_q[tail_q]  <= req_addr_q;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_addr;
    assign bus.instr       = data_q[head_q];
    assign bus.instr_pc    = epc_q[head_q];
    assign bus.instr_valid = (count_q != '0);

endmodule

// File: tb/tb_instr_byte_fetch.sv
module tb_instr_byte_fetch;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 16;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    instr_byte_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    instr_byte_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit          rand_ready = 1'b0;
    bit          chk_stable = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr  = 16'h0;
    logic        acc;
    logic [15:0] acc_addr;
    logic        acc_in_rst;

    typedef struct {
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ipc;
        logic [7:0]  ins;
    } vec_t;
    vec_t tbl[8];

    // Memory contents: reset vector 1234, other bytes a hash of the address.
    function automatic logic [7:0] memval(input logic [15:0] a);
        if (a == 16'hFFFC) return 8'h34;
        if (a == 16'hFFFD) return 8'h12;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Memory responder: one-cycle response to every accepted request.
    // Requests accepted while reset is held return a junk byte.
    initial begin
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 8'h00;
        forever begin
            @(posedge clk_i);
            acc        = bus.mem_req & bus.mem_ready;
            acc_addr   = bus.mem_addr;
            acc_in_rst = ~rst_ni;
            if (chk_stable && prev_stall && rst_ni) begin
                check("req_held", 32'(bus.mem_req), 32'd1);
                check("addr_held", 32'(bus.mem_addr), 32'(prev_addr));
            end
            prev_stall = bus.mem_req & ~bus.mem_ready;
            prev_addr  = bus.mem_addr;
            #1;
            bus.mem_rvalid = acc;
            bus.mem_rdata  = acc_in_rst ? 8'hEE : memval(acc_addr);
            bus.mem_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // One cycle: drive inputs just after the edge, return at the falling edge.
    task automatic cyc(input logic rdy, input logic redir, input logic [15:0] rpc);
        @(posedge clk_i);
        #1;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        @(negedge clk_i);
    endtask

    // Releases reset in row 0 and checks cycles 0..7 of the vector sequence.
    task automatic run_vec_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            rst_ni          = 1'b1;
            bus.instr_ready = tbl[i].rdy;
            bus.redirect    = 1'b0;
            @(negedge clk_i);
            check($sformatf("%s_req_c%0d", tag, i), 32'(bus.mem_req), 32'(tbl[i].req));
            if (tbl[i].req)
                check($sformatf("%s_addr_c%0d", tag, i), 32'(bus.mem_addr), 32'(tbl[i].addr));
            check($sformatf("%s_vld_c%0d", tag, i), 32'(bus.instr_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                check($sformatf("%s_pc_c%0d", tag, i), 32'(bus.instr_pc), 32'(tbl[i].ipc));
                check($sformatf("%s_ins_c%0d", tag, i), 32'(bus.instr), 32'(tbl[i].ins));
            end
        end
    endtask

    initial begin
        int          acc_n;
        int          pops;
        int          used;
        logic [15:0] want_pc;
        logic [15:0] wrap_exp[4];

        tbl[0] = '{1'b1, 1'b1, 16'hFFFC, 1'b0, 16'h0000, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 16'hFFFD, 1'b0, 16'h0000, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 8'h00};
        tbl[4] = '{1'b1, 1'b1, 16'h1235, 1'b0, 16'h0000, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 16'h1236, 1'b1, 16'h1234, memval(16'h1234)};
        tbl[6] = '{1'b1, 1'b1, 16'h1237, 1'b1, 16'h1235, memval(16'h1235)};
        tbl[7] = '{1'b1, 1'b1, 16'h1238, 1'b1, 16'h1236, memval(16'h1236)};
        wrap_exp[0] = 16'hFFFE;
        wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000;
        wrap_exp[3] = 16'h0001;

        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0;
        rst_ni          = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_req", 32'(bus.mem_req), 32'd1);
        check("rst_addr", 32'(bus.mem_addr), 32'hFFFC);
        check("rst_vld", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_ipc", 32'(bus.instr_pc), 32'd0);

        // Reset vector and first bytes
        run_vec_table("vec");

        // Backpressure: 20 stalled cycles after a redirect to 2000
        cyc(1'b0, 1'b1, 16'h2000);
        check("bp_req_in_redirect", 32'(bus.mem_req), 32'd0);
        acc_n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 16'h0);
            if (bus.mem_req && bus.mem_ready) acc_n++;
        end
        check("bp_accepted", 32'(acc_n), 32'(DEPTH));
        check("bp_req_low", 32'(bus.mem_req), 32'd0);
        check("bp_vld", 32'(bus.instr_valid), 32'd1);
        check("bp_head_pc", 32'(bus.instr_pc), 32'h2000);
        check("bp_head_ins", 32'(bus.instr), 32'(memval(16'h2000)));

        // Drain: 16 bytes in order, one per cycle
        want_pc = 16'h2000;
        pops    = 0;
        used    = 0;
        for (int i = 0; i < 60 && pops < 16; i++) begin
            cyc(1'b1, 1'b0, 16'h0);
            used++;
            if (bus.instr_valid) begin
                check("drain_pc", 32'(bus.instr_pc), 32'(want_pc));
                check("drain_ins", 32'(bus.instr), 32'(memval(want_pc)));
                want_pc = want_pc + 16'd1;
                pops++;
            end
        end
        check("drain_count", 32'(pops), 32'd16);
        check("drain_cycles", 32'(used), 32'd16);

        // Redirect while a response is in flight
        cyc(1'b1, 1'b1, 16'h2000);
        cyc(1'b1, 1'b0, 16'h0);
        check("rdf_vld_r1", 32'(bus.instr_valid), 32'd0);
        check("rdf_addr_r1", 32'(bus.mem_addr), 32'h2000);
        check("rdf_req_r1", 32'(bus.mem_req), 32'd1);
        cyc(1'b1, 1'b1, 16'h8000);
        check("rdf_req_forced_low", 32'(bus.mem_req), 32'd0);
        cyc(1'b1, 1'b0, 16'h0);
        check("rdf_vld_after", 32'(bus.instr_valid), 32'd0);
        check("rdf_addr_8000", 32'(bus.mem_addr), 32'h8000);
        cyc(1'b1, 1'b0, 16'h0);
        check("rdf_vld_r4", 32'(bus.instr_valid), 32'd0);
        cyc(1'b1, 1'b0, 16'h0);
        check("rdf_vld_r5", 32'(bus.instr_valid), 32'd1);
        check("rdf_pc_r5", 32'(bus.instr_pc), 32'h8000);
        check("rdf_ins_r5", 32'(bus.instr), 32'(memval(16'h8000)));
        cyc(1'b1, 1'b0, 16'h0);
        check("rdf_pc_r6", 32'(bus.instr_pc), 32'h8001);

        // PC wrap
        cyc(1'b1, 1'b1, 16'hFFFE);
        pops = 0;
        for (int i = 0; i < 12 && pops < 4; i++) begin
            cyc(1'b1, 1'b0, 16'h0);
            if (bus.instr_valid) begin
                check($sformatf("wrap_pc%0d", pops), 32'(bus.instr_pc), 32'(wrap_exp[pops]));
                pops++;
            end
        end
        check("wrap_count", 32'(pops), 32'd4);

        // Random memory stalls across vector fetch and streaming
        @(posedge clk_i);
        #1;
        rst_ni     = 1'b0;
        rand_ready = 1'b1;
        chk_stable = 1'b1;
        repeat (2) cyc(1'b1, 1'b0, 16'h0);
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        want_pc = 16'h1234;
        pops    = 0;
        for (int i = 0; i < 400 && pops < 20; i++) begin
            cyc(1'b1, 1'b0, 16'h0);
            if (bus.instr_valid) begin
                check("stall_pc", 32'(bus.instr_pc), 32'(want_pc));
                check("stall_ins", 32'(bus.instr), 32'(memval(want_pc)));
                want_pc = want_pc + 16'd1;
                pops++;
            end
        end
        check("stall_count", 32'(pops), 32'd20);
        chk_stable = 1'b0;
        rand_ready = 1'b0;

        // Mid-run reset with queued bytes and a response in flight
        repeat (4) cyc(1'b0, 1'b0, 16'h0);
        check("mrst_pre_vld", 32'(bus.instr_valid), 32'd1);
        check("mrst_pre_req", 32'(bus.mem_req & bus.mem_ready), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("mrst_vld", 32'(bus.instr_valid), 32'd0);
        check("mrst_instr", 32'(bus.instr), 32'd0);
        check("mrst_ipc", 32'(bus.instr_pc), 32'd0);
        check("mrst_req", 32'(bus.mem_req), 32'd1);
        check("mrst_addr", 32'(bus.mem_addr), 32'hFFFC);
        run_vec_table("mrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_byte_fetch.md
# instr_byte_fetch

Upstream byte-fetch stage for the frontend: after reset it reads the 6502 reset vector, then streams sequential opcode/operand bytes from instruction memory into a small FIFO. It presents them one per cycle on the `instr`/`instr_valid`/`instr_ready` handshake that the frontend's macro-op fetch consumes. A redirect port (from branch/jump resolution) flushes the queue and restarts fetch at a new PC.

## Interface

- `DEPTH`, 8: FIFO entries. Must be ≥2.
- `ADDR_W`, 16: PC and memory address width.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `mem_addr` out ADDR_W: request address.
- `mem_req` out 1: request valid.
- `mem_ready` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: response valid. Asserted exactly one cycle after each accepted request.
- `mem_rdata` in 8: response byte.
- `redirect` in 1: flush and restart fetch.
- `redirect_pc` in ADDR_W: new fetch PC.
- `instr` out 8: byte at the FIFO head.
- `instr_pc` out ADDR_W: address of the head byte.
- `instr_valid` out 1: FIFO non-empty.
- `instr_ready` in 1: consumer takes the head byte.

## Operation

**States:**
- VEC_LO: request address `FFFC`.
- VEC_HI: request `FFFD` and capture the low-byte response.
- VEC_WAIT: capture the high-byte response, then go to RUN with `pc = {hi, lo}`.
- RUN: streaming fetch.

VEC_LO advances to VEC_HI only when `mem_ready`; VEC_HI advances to VEC_WAIT only when `mem_ready`.

**Registers:**
- `pc`: next fetch address.
- `count`: occupancy, width `$clog2(DEPTH+1)`.
- Head and tail pointers: wrap modulo DEPTH.
- `inflight`: 1 bit; a request was accepted last cycle.
- Per entry: `{pc, byte}`.

**RUN request and push:**
- `mem_req = (count + inflight < DEPTH) & ~redirect`; `mem_addr = pc`.
- On accept (`mem_req & mem_ready`): increment `pc` modulo 2^ADDR_W (`FFFF` wraps to `0000`), set `inflight`, and record the request address for the push.
- On `mem_rvalid` with `inflight` and no redirect: push `{req_addr, mem_rdata}` at the tail.

**Pop:** when `instr_valid & instr_ready`. Push and pop in the same cycle leave `count` unchanged.

**Credit rule:** the request condition counts the in-flight response against capacity and gives no credit for a same-cycle pop. This guarantees a push never arrives when the FIFO is full. Overflow is impossible by construction; underflow cannot occur because `instr_valid` gates pop.

**Redirect** (any state, highest priority):
- `count`, head and tail go to 0.
- `pc` ← `redirect_pc`; state ← RUN.
- `mem_req` is forced low that cycle.
- A response arriving in the redirect cycle is discarded; `inflight` clears.
- A pop in the same cycle is ignored; the flush wins.

**Vector fetch:** `mem_req` is held high in VEC_LO and VEC_HI regardless of FIFO state, with `mem_addr` = `FFFC` and `FFFD` respectively. Vector bytes are never pushed.

**Reset (asserted):**
- State = VEC_LO; `pc`, `count`, pointers and `inflight` = 0.
- Outputs: `mem_req`=1, `mem_addr`=`FFFC`, `instr_valid`=0, `instr`=0, `instr_pc`=0 (FIFO storage is zeroed).

Reset asserted mid-operation aborts everything immediately. Any `mem_rvalid` seen in the first cycle after release is ignored, because `inflight`=0.

## Timing

- **Fetch latency:** request accepted at cycle T, response at T+1, `instr_valid` at T+2. No push-to-output bypass.
- **Throughput:** 1 byte/cycle sustained when `instr_ready` is held high and `mem_ready` is 1.
- **Reset vector:** with `mem_ready`=1, release at cycle 0 gives requests at 0 (`FFFC`) and 1 (`FFFD`), VEC_WAIT at 2, RUN at 3 issuing the vector address. The first `instr_valid` is at cycle 5.
- **Redirect:** asserted in cycle R, the request to `redirect_pc` is issued at R+1 and the byte becomes valid at R+3. `instr_valid` drops at R+1.
- **Stall:** with `instr_ready`=0, requests stop once `count + inflight = DEPTH`. `instr`/`instr_pc` remain stable while `instr_valid & ~instr_ready`.

## Test plan

- **Reset vector:** memory holds `FFFC`=`34`, `FFFD`=`12`, always ready; release reset → requests to `FFFC`, `FFFD`, then `1234`, `1235`, …; first `instr_pc`=`1234` at cycle 5.
- **Backpressure:** DEPTH=8, `instr_ready`=0 for 20 cycles → exactly 8 requests accepted, `mem_req` low afterwards. Then ready=1 → bytes drain in address order with no loss or duplication.
- **Redirect with response in flight:** in RUN at pc `2000`, pulse `redirect` to `8000` in the response cycle → that response is dropped, `instr_valid`=0 next cycle, next output `instr_pc`=`8000`.
- **PC wrap:** redirect to `FFFE` → output PCs `FFFE`, `FFFF`, `0000`, `0001`.
- **Memory stalls:** `mem_ready` toggling randomly during vector fetch and RUN → vector taken correctly, output stream contiguous, `mem_req`/`mem_addr` held stable until accepted.
- **Mid-run reset:** `rst` low with a non-empty FIFO and a response in flight → `instr_valid`=0 immediately, vector fetch restarts, stale `mem_rvalid` ignored.
